// File: rtl/int_seq_pkg.sv
// Shared definitions for the interrupt sequencer: FSM state encodings,
// the condition-code and stack word widths, and a helper that packs the
// saved CCR into a stack word.
package int_seq_pkg;

    localparam int CCR_W = 3;
    localparam int STK_W = 16;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] DRAIN    = 3'd1;
    localparam logic [2:0] PUSH_HI  = 3'd2;
    localparam logic [2:0] PUSH_LO  = 3'd3;
    localparam logic [2:0] PUSH_CCR = 3'd4;
    localparam logic [2:0] VEC_HI   = 3'd5;
    localparam logic [2:0] VEC_LO   = 3'd6;
    localparam logic [2:0] LOAD     = 3'd7;

    function automatic logic [STK_W-1:0] ccr_word(input logic [CCR_W-1:0] c);
        return {{(STK_W-CCR_W){1'b0}}, c};
    endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Stack-push and vector-read handshake between the interrupt sequencer
// (master) and the data-memory arbiter (slave).
interface interrupt_sequencer_if #(
    parameter int ADDR_W = 12
);
    import int_seq_pkg::*;

    logic              push_req;
    logic [STK_W-1:0]  push_data;
    logic              push_ack;
    logic              vec_req;
    logic [ADDR_W-1:0] vec_addr;
    logic              vec_ack;
    logic [STK_W-1:0]  vec_data;

    modport master (
        output push_req, push_data, vec_req, vec_addr,
        input  push_ack, vec_ack, vec_data
    );

    modport slave (
        input  push_req, push_data, vec_req, vec_addr,
        output push_ack, vec_ack, vec_data
    );
endinterface

// File: rtl/int_edge_detect.sv
// Rising-edge detector for the interrupt pin.
// Build option INT_SYNC_EN: when defined, the pin first passes through a
// 2-flop synchronizer (adds two cycles of request latency).
module int_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic interrupt,
    output logic rise
);
    logic level;
    logic prev;

`ifdef INT_SYNC_EN
    logic sync_1;
    logic sync_2;

    // Two-stage synchronizer for an asynchronous interrupt pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= interrupt;
            sync_2 <= sync_1;
        end
    end

    assign level = sync_2;
`else
    assign level = interrupt;
`endif

    // Previous level; reset to 1 so a pin already high at reset release is
    // not mistaken for a fresh request -- it must go low first.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b1;
        end else begin
            prev <= level;
        end
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: freezes fetch, drains the pipeline, pushes
// return PC and CCR onto the stack, reads the ISR vector and loads the PC.
// Build option INT_SYNC_EN (see int_edge_detect) adds a pin synchronizer.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for a pending request with no multicycle op in ID
// DRAIN    | fetch frozen, letting in-flight instructions retire
// PUSH_HI  | pushing ret_pc upper half, waiting for push_ack
// PUSH_LO  | pushing ret_pc lower half, waiting for push_ack
// PUSH_CCR | pushing saved CCR, waiting for push_ack
// VEC_HI   | reading vector high word at VEC_ADDR
// VEC_LO   | reading vector low word at VEC_ADDR+1
// LOAD     | one-cycle PC load strobe and int_ack
module interrupt_sequencer
    import int_seq_pkg::*;
#(
    parameter int                DRAIN_CYCLES = 4,
    parameter int                ADDR_W       = 12,
    parameter logic [ADDR_W-1:0] VEC_ADDR     = '0,
    parameter int                PC_W         = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 interrupt,
    input  logic                 id_multicycle,
    input  logic [PC_W-1:0]      resume_pc,
    input  logic [CCR_W-1:0]     ccr,
    output logic                 freeze_fetch,
    interrupt_sequencer_if.master mem,
    output logic                 pc_load,
    output logic [PC_W-1:0]      pc_load_val,
    output logic                 int_busy,
    output logic                 int_ack
);
    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [ADDR_W-1:0] VEC_ADDR_LO = VEC_ADDR + ADDR_W'(1);

    logic [2:0]       state;
    logic             pending;
    logic             int_rise;
    logic             start;
    logic [CNT_W-1:0] drain_cnt;
    logic [PC_W-1:0]  ret_pc;
    logic [CCR_W-1:0] sav_ccr;
    logic [STK_W-1:0] vec_hi;
    logic [STK_W-1:0] vec_lo;

    int_edge_detect u_edge (
        .clk       (clk),
        .rst       (rst),
        .interrupt (interrupt),
        .rise      (int_rise)
    );

    // A fresh edge may start service in the same cycle it is seen, so the
    // first DRAIN cycle follows the edge directly.
    assign start = (state == IDLE) && (pending || int_rise) && !id_multicycle;

    // Single-entry request latch; edges while busy merge into it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (start) begin
            pending <= 1'b0;
        end else if (int_rise) begin
            pending <= 1'b1;
        end
    end

    // Sequencing FSM with context capture and vector word capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            drain_cnt <= '0;
            ret_pc    <= '0;
            sav_ccr   <= '0;
            vec_hi    <= '0;
            vec_lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= DRAIN;
                        ret_pc    <= resume_pc;
                        sav_ccr   <= ccr;
                        drain_cnt <= DRAIN_LOAD;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= PUSH_HI;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                PUSH_HI:  if (mem.push_ack) state <= PUSH_LO;
                PUSH_LO:  if (mem.push_ack) state <= PUSH_CCR;
                PUSH_CCR: if (mem.push_ack) state <= VEC_HI;
                VEC_HI: begin
                    if (mem.vec_ack) begin
                        vec_hi <= mem.vec_data;
                        state  <= VEC_LO;
                    end
                end
                VEC_LO: begin
                    if (mem.vec_ack) begin
                        vec_lo <= mem.vec_data;
                        state  <= LOAD;
                    end
                end
                LOAD:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Output decode; every output is zero outside the state that uses it.
    always_comb begin
        freeze_fetch  = (state != IDLE);
        int_busy      = (state != IDLE);
        mem.push_req  = 1'b0;
        mem.push_data = '0;
        mem.vec_req   = 1'b0;
        mem.vec_addr  = '0;
        pc_load       = 1'b0;
        int_ack       = 1'b0;
        pc_load_val   = '0;
        case (state)
            PUSH_HI: begin
                mem.push_req  = 1'b1;
                mem.push_data = ret_pc[PC_W-1 -: STK_W];
            end
            PUSH_LO: begin
                mem.push_req  = 1'b1;
                mem.push_data = ret_pc[STK_W-1:0];
            end
            PUSH_CCR: begin
                mem.push_req  = 1'b1;
                mem.push_data = ccr_word(sav_ccr);
            end
            VEC_HI: begin
                mem.vec_req  = 1'b1;
                mem.vec_addr = VEC_ADDR;
            end
            VEC_LO: begin
                mem.vec_req  = 1'b1;
                mem.vec_addr = VEC_ADDR_LO;
            end
            LOAD: begin
                pc_load     = 1'b1;
                int_ack     = 1'b1;
                pc_load_val = PC_W'({vec_hi, vec_lo});
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench for interrupt_sequencer. The vector is placed at 12'hFFF
// so every sequence also exercises the VEC_ADDR+1 wrap to 12'h000.
module tb_interrupt_sequencer;

    localparam logic [11:0] VEC_ADDR = 12'hFFF;
    localparam int EV_PUSH = 0;
    localparam int EV_VEC  = 1;
    localparam int EV_LOAD = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        interrupt;
    logic        id_multicycle;
    logic [31:0] resume_pc;
    logic [2:0]  ccr;
    logic        freeze_fetch;
    logic        pc_load;
    logic [31:0] pc_load_val;
    logic        int_busy;
    logic        int_ack;

    interrupt_sequencer_if #(.ADDR_W(12)) mem_bus ();

    interrupt_sequencer #(
        .DRAIN_CYCLES (4),
        .ADDR_W       (12),
        .VEC_ADDR     (VEC_ADDR),
        .PC_W         (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .interrupt     (interrupt),
        .id_multicycle (id_multicycle),
        .resume_pc     (resume_pc),
        .ccr           (ccr),
        .freeze_fetch  (freeze_fetch),
        .mem           (mem_bus),
        .pc_load       (pc_load),
        .pc_load_val   (pc_load_val),
        .int_busy      (int_busy),
        .int_ack       (int_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          kind;
        logic [31:0] val;
        int          at;
    } exp_t;
    exp_t sb[$];

    logic [15:0] vec_mem_hi;
    logic [15:0] vec_mem_lo;
    int          push_delay[3];
    int          push_idx;
    int          wait_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [31:0] val, input int at);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.at   = at;
        sb.push_back(e);
    endtask

    task automatic expect_seq(input int t, input logic [31:0] pc, input logic [2:0] c,
                              input logic [31:0] vec, input int lo_extra);
        expect_ev(EV_PUSH, {16'h0, pc[31:16]}, t + 5);
        expect_ev(EV_PUSH, {16'h0, pc[15:0]}, t + 6 + lo_extra);
        expect_ev(EV_PUSH, {29'h0, c}, t + 7 + lo_extra);
        expect_ev(EV_VEC, 32'h0000_0FFF, t + 8 + lo_extra);
        expect_ev(EV_VEC, 32'h0000_0000, t + 9 + lo_extra);
        expect_ev(EV_LOAD, vec, t + 10 + lo_extra);
    endtask

    task automatic got_ev(input int kind, input logic [31:0] val);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d value %h, expected none (cycle %0d)",
                     kind, val, cyc);
        end else begin
            e = sb.pop_front();
            check("ev_kind", 32'(kind), 32'(e.kind));
            check("ev_value", val, e.val);
            check("ev_cycle", 32'(cyc), 32'(e.at));
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_freeze"}, 32'(freeze_fetch), 0);
        check({tag, "_busy"}, 32'(int_busy), 0);
        check({tag, "_push_req"}, 32'(mem_bus.push_req), 0);
        check({tag, "_push_data"}, 32'(mem_bus.push_data), 0);
        check({tag, "_vec_req"}, 32'(mem_bus.vec_req), 0);
        check({tag, "_vec_addr"}, 32'(mem_bus.vec_addr), 0);
        check({tag, "_pc_load"}, 32'(pc_load), 0);
        check({tag, "_pc_load_val"}, pc_load_val, 0);
        check({tag, "_int_ack"}, 32'(int_ack), 0);
    endtask

    // Memory-side responder: stack pushes with per-word ack delay, vector
    // reads answered in the same cycle.
    initial begin
        mem_bus.push_ack = 1'b0;
        mem_bus.vec_ack  = 1'b0;
        mem_bus.vec_data = 16'h0;
        push_idx = 0;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            mem_bus.push_ack = 1'b0;
            mem_bus.vec_ack  = 1'b0;
            mem_bus.vec_data = 16'h0;
            if (rst === 1'b1) begin
                push_idx = 0;
                wait_cnt = 0;
            end
            if (mem_bus.push_req === 1'b1) begin
                if (wait_cnt >= push_delay[push_idx]) begin
                    mem_bus.push_ack = 1'b1;
                    wait_cnt = 0;
                    push_idx = (push_idx + 1) % 3;
                end else begin
                    wait_cnt++;
                end
            end
            if (mem_bus.vec_req === 1'b1) begin
                mem_bus.vec_ack  = 1'b1;
                mem_bus.vec_data = (mem_bus.vec_addr == VEC_ADDR) ? vec_mem_hi : vec_mem_lo;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT completes a transfer.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mem_bus.push_req === 1'b1 || mem_bus.vec_req === 1'b1)
                check("req_exclusive", 32'(mem_bus.push_req & mem_bus.vec_req), 0);
            if (mem_bus.push_req === 1'b1 && mem_bus.push_ack === 1'b1)
                got_ev(EV_PUSH, {16'h0, mem_bus.push_data});
            if (mem_bus.vec_req === 1'b1 && mem_bus.vec_ack === 1'b1)
                got_ev(EV_VEC, {20'h0, mem_bus.vec_addr});
            if (pc_load === 1'b1) begin
                got_ev(EV_LOAD, pc_load_val);
                check("int_ack_with_load", 32'(int_ack), 1);
            end
        end
    end

    initial begin
        #50000;
        errors++;
        $display("FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int t;
        rst = 1'b1;
        interrupt = 1'b0;
        id_multicycle = 1'b0;
        resume_pc = 32'h0;
        ccr = 3'b000;
        vec_mem_hi = 16'h0;
        vec_mem_lo = 16'h0;
        for (int i = 0; i < 3; i++) push_delay[i] = 0;

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // Basic sequence, interrupt level held high throughout.
        @(negedge clk);
        t = cyc;
        resume_pc = 32'h0001_0234;
        ccr = 3'b101;
        vec_mem_hi = 16'h0000;
        vec_mem_lo = 16'h0100;
        interrupt = 1'b1;
        expect_seq(t, 32'h0001_0234, 3'b101, 32'h0000_0100, 0);
        wait_cyc(t + 1);
        check("basic_drain_freeze", 32'(freeze_fetch), 1);
        check("basic_drain_busy", 32'(int_busy), 1);
        resume_pc = 32'hFFFF_FFFF;
        ccr = 3'b000;
        wait_cyc(t + 10);
        check("basic_load_freeze", 32'(freeze_fetch), 1);
        wait_cyc(t + 11);
        check("basic_end_freeze", 32'(freeze_fetch), 0);
        check("basic_end_busy", 32'(int_busy), 0);
        wait_cyc(t + 14);
        check("level_single_request", 32'(int_busy), 0);
        interrupt = 1'b0;

        // Deferred start behind a multicycle instruction in ID.
        wait_cyc(t + 16);
        t = cyc;
        id_multicycle = 1'b1;
        interrupt = 1'b1;
        resume_pc = 32'h1234_5678;
        ccr = 3'b010;
        vec_mem_hi = 16'hABCD;
        vec_mem_lo = 16'h0042;
        expect_seq(t + 3, 32'h1234_5678, 3'b010, 32'hABCD_0042, 0);
        wait_cyc(t + 1);
        interrupt = 1'b0;
        check("defer_busy_1", 32'(int_busy), 0);
        check("defer_freeze_1", 32'(freeze_fetch), 0);
        wait_cyc(t + 2);
        check("defer_busy_2", 32'(int_busy), 0);
        wait_cyc(t + 3);
        check("defer_busy_3", 32'(int_busy), 0);
        id_multicycle = 1'b0;
        wait_cyc(t + 4);
        check("defer_drain_start", 32'(freeze_fetch), 1);
        wait_cyc(t + 5);
        id_multicycle = 1'b1;
        wait_cyc(t + 14);
        check("defer_end_busy", 32'(int_busy), 0);
        id_multicycle = 1'b0;

        // Backpressure: two extra wait cycles on the PC low-half push.
        wait_cyc(t + 16);
        t = cyc;
        push_delay[1] = 2;
        resume_pc = 32'h0001_0234;
        ccr = 3'b111;
        vec_mem_hi = 16'h0000;
        vec_mem_lo = 16'h0200;
        interrupt = 1'b1;
        expect_seq(t, 32'h0001_0234, 3'b111, 32'h0000_0200, 2);
        wait_cyc(t + 1);
        interrupt = 1'b0;
        for (int k = 6; k <= 8; k++) begin
            wait_cyc(t + k);
            check("bp_push_req", 32'(mem_bus.push_req), 1);
            check("bp_push_data", 32'(mem_bus.push_data), 32'h0234);
            check("bp_no_vec_req", 32'(mem_bus.vec_req), 0);
        end
        wait_cyc(t + 13);
        check("bp_end_busy", 32'(int_busy), 0);
        push_delay[1] = 0;

        // Queued request during PUSH_CCR, plus a merged third edge.
        wait_cyc(t + 15);
        t = cyc;
        resume_pc = 32'h0000_8000;
        ccr = 3'b001;
        vec_mem_hi = 16'h0001;
        vec_mem_lo = 16'h2345;
        interrupt = 1'b1;
        expect_seq(t, 32'h0000_8000, 3'b001, 32'h0001_2345, 0);
        expect_seq(t + 11, 32'h7FFF_FFFE, 3'b110, 32'h00AB_CDEF, 0);
        wait_cyc(t + 3);
        interrupt = 1'b0;
        wait_cyc(t + 7);
        check("queue_in_push_ccr", 32'(mem_bus.push_data), 32'h0001);
        interrupt = 1'b1;
        wait_cyc(t + 8);
        interrupt = 1'b0;
        resume_pc = 32'h7FFF_FFFE;
        ccr = 3'b110;
        wait_cyc(t + 9);
        interrupt = 1'b1;
        wait_cyc(t + 10);
        interrupt = 1'b0;
        vec_mem_hi = 16'h00AB;
        vec_mem_lo = 16'hCDEF;
        wait_cyc(t + 11);
        check("queue_idle_gap", 32'(int_busy), 0);
        wait_cyc(t + 12);
        check("queue_second_start", 32'(int_busy), 1);
        wait_cyc(t + 22);
        check("queue_second_end", 32'(int_busy), 0);
        wait_cyc(t + 26);
        check("queue_third_merged", 32'(int_busy), 0);

        // Reset while reading the vector high word.
        t = cyc;
        resume_pc = 32'h0BAD_F00D;
        ccr = 3'b011;
        vec_mem_hi = 16'h0001;
        vec_mem_lo = 16'h0001;
        interrupt = 1'b1;
        expect_ev(EV_PUSH, 32'h0000_0BAD, t + 5);
        expect_ev(EV_PUSH, 32'h0000_F00D, t + 6);
        expect_ev(EV_PUSH, 32'h0000_0003, t + 7);
        expect_ev(EV_VEC, 32'h0000_0FFF, t + 8);
        wait_cyc(t + 8);
        check("rst_in_vec_hi", 32'(mem_bus.vec_req), 1);
        rst = 1'b1;
        wait_cyc(t + 9);
        rst = 1'b0;
        check_idle_outputs("after_rst");
        for (int k = 10; k <= 16; k++) begin
            wait_cyc(t + k);
            check("held_level_ignored", 32'(int_busy), 0);
        end
        interrupt = 1'b0;

        // Recovery: a one-cycle pulse after reset is serviced normally.
        wait_cyc(t + 18);
        t = cyc;
        resume_pc = 32'hCAFE_0001;
        ccr = 3'b100;
        vec_mem_hi = 16'h8000;
        vec_mem_lo = 16'h0010;
        interrupt = 1'b1;
        expect_seq(t, 32'hCAFE_0001, 3'b100, 32'h8000_0010, 0);
        wait_cyc(t + 1);
        interrupt = 1'b0;
        check("recover_start", 32'(int_busy), 1);
        wait_cyc(t + 13);
        check("recover_end", 32'(int_busy), 0);

        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
